uart_bus: RTL and testbench
===========================

# uart_bus

UART-to-bus bridge for the LPC command link. Receives 8N1 bytes on the TX1 line (LPC TXD1), parses them into single read/write command frames, and issues one Wishbone-style master cycle per frame onto the internal 8-bit bus alongside `krake_bus`. Read data is returned through the existing `read_fifo` → RX1 path; this block also latches the read data locally for status and debug.

## Interface
- `CLKS_PER_BIT`, 434, clk_i cycles per UART bit; minimum 4; 16-bit counter.
- `ACK_TIMEOUT`, 255, clk_i cycles to wait for `ack_i` before aborting; range 1..65535.
- `clk_i`  in  1  system clock
- `rst_i`  in  1  reset, **asynchronous, active-low**
- `rx_i`  in  1  serial input (TX1); idle high; asynchronous to clk_i
- `ack_i`  in  1  bus acknowledge from the address-decoded slave mux
- `dat_i`  in  8  bus read data
- `stb_o`  out  1  bus strobe
- `we_o`  out  1  bus write enable
- `adr_o`  out  8  bus address
- `dat_o`  out  8  bus write data
- `rd_dat_o`  out  8  last read data
- `rd_valid_o`  out  1  1-cycle pulse when `rd_dat_o` updates
- `err_o`  out  1  1-cycle pulse on framing error, overrun or ack timeout

## Operation
- **Input conditioning:** `rx_i` passes through a 2-FF synchronizer whose flops reset to 1.
- **RX FSM:**
  - R_IDLE: on synchronized low, go to R_START and load the bit counter with `CLKS_PER_BIT/2` (integer division).
  - R_START: at count expiry, re-sample the line. Low goes to R_DATA with the counter reloaded to `CLKS_PER_BIT`. High is a glitch: return to R_IDLE with no error.
  - R_DATA: sample 8 bits LSB first, one per `CLKS_PER_BIT`, then go to R_STOP.
  - R_STOP: at mid-stop, a high line pulses `byte_valid` internally for 1 cycle. A low line pulses `err_o` and drops the byte. Both cases return to R_IDLE.
- **Frame parser** (consumes `byte_valid`):
  - P_HDR:
    - 0xA5 = write, go to P_ADR.
    - 0x5A = read, go to P_ADR.
    - Any other byte is silently discarded; stay in P_HDR. This is the resync mechanism.
  - P_ADR: latch `adr_o`. Write goes to P_DAT; read goes to P_BUS.
  - P_DAT: latch `dat_o`, go to P_BUS.
  - P_BUS:
    - On entry, assert `stb_o` and drive `we_o` from the header; `adr_o`/`dat_o` stay stable throughout.
    - On `ack_i`=1, deassert `stb_o`/`we_o` and return to P_HDR. For a read, also latch `dat_i` into `rd_dat_o` and pulse `rd_valid_o`.
    - If no ack within `ACK_TIMEOUT` cycles of `stb_o` rising: deassert, pulse `err_o`, return to P_HDR; `rd_dat_o` is unchanged.
- **Overrun:** a byte completing while in P_BUS is dropped and pulses `err_o`. The RX FSM keeps running regardless of parser state.
- **`err_o` collision:** a framing error and a timeout in the same cycle give a single `err_o` pulse.
- **`we_o`** is 0 whenever `stb_o` is 0.

## Timing
- **Reset values:** `stb_o`=0, `we_o`=0, `adr_o`=0x00, `dat_o`=0x00, `rd_dat_o`=0x00, `rd_valid_o`=0, `err_o`=0. FSMs reset to R_IDLE/P_HDR.
- **Reset mid-frame:** asserting `rst_i` aborts any partial frame or bus cycle immediately (asynchronously); `stb_o` drops without waiting for ack.
- **Start-bit latency:** 2 synchronizer cycles + start detect.
- **Sample points:** the stop-bit sample lands about 9.5 bit times after the falling edge.
- **Strobe rise:** `stb_o` rises on the clock edge after the `byte_valid` of the final frame byte.
- **Strobe fall:** `ack_i` is sampled each edge while `stb_o`=1. `stb_o` falls on the same edge that samples `ack_i`=1, so with a combinational-ack slave the minimum strobe is 1 cycle. `rd_valid_o` pulses on that same edge.
- **Timeout:** the counter starts at 0 on the `stb_o` rising edge. Abort occurs on the edge where the count reaches `ACK_TIMEOUT` with `ack_i` still low. An `ack_i` on that exact edge wins over the timeout.
- **Throughput:** back-to-back frames with no idle gap are accepted. The bus cycle must complete within one byte time to avoid overrun.

## Test plan
- **Write frame:** `CLKS_PER_BIT`=4; send 0xA5, 0x12, 0x3C; slave acks after 2 cycles → exactly one strobe with `adr_o`=0x12, `dat_o`=0x3C, `we_o`=1, lasting 3 cycles; `err_o` never pulses.
- **Read frame:** send 0x5A, 0x21; slave returns `dat_i`=0x77 with ack → `we_o`=0 throughout; `rd_dat_o`=0x77; one `rd_valid_o` pulse on the ack edge.
- **Resync:** send 0x00, 0xFF, then 0xA5, 0x40, 0x01 → no strobe for the first two bytes; one write to 0x40 with data 0x01.
- **Framing error:** send 0xA5 with stop bit low, then 0x5A, 0x30 → one `err_o` pulse; the 0xA5 is discarded; one read of 0x30 follows.
- **Timeout:** `ACK_TIMEOUT`=8; write frame with `ack_i` held 0 → `stb_o` high for exactly 8 cycles; one `err_o` pulse; the next frame executes normally.
- **Reset mid-operation:** pulse `rst_i` low during the P_DAT byte and again during an active strobe → all outputs return to reset values immediately; the next complete frame executes correctly.

Source files
------------

// File: rtl/uart_bus.sv
// UART-to-bus bridge: receives 8N1 command frames (0xA5 adr dat = write, 0x5A adr = read)
// and runs one strobe/ack bus cycle per frame, with ack timeout and error reporting.
module uart_bus #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  input  logic       ack_i,
  input  logic [7:0] dat_i,
  output logic       stb_o,
  output logic       we_o,
  output logic [7:0] adr_o,
  output logic [7:0] dat_o,
  output logic [7:0] rd_dat_o,
  output logic       rd_valid_o,
  output logic       err_o
);

  localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] FULL_BIT = 16'(CLKS_PER_BIT);
  localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {P_HDR, P_ADR, P_DAT, P_BUS} p_state_t;

  logic       rx_p0, rx_p1;
  rx_state_t  rx_state;
  logic [15:0] bit_cnt;
  logic [2:0] bit_idx;
  logic [7:0] rx_byte;
  logic       byte_valid, frame_err;
  logic       bit_tick;

  p_state_t   p_state;
  logic       is_wr;
  logic [15:0] ack_cnt;
  logic       ack_expire, overrun;

  // input synchronizer, idles high
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx_i;
      rx_p1 <= rx_p0;
    end
  end

  assign bit_tick = (bit_cnt == 16'd1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_state   <= R_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (rx_state != R_IDLE && !bit_tick) bit_cnt <= bit_cnt - 16'd1;
      case (rx_state)
        R_IDLE: if (!rx_p1) begin
          rx_state <= R_START;
          bit_cnt  <= HALF_BIT;
        end
        R_START: if (bit_tick) begin
          // a line back high at mid-start is a glitch, not an error
          if (!rx_p1) begin
            rx_state <= R_DATA;
            bit_cnt  <= FULL_BIT;
            bit_idx  <= '0;
          end else begin
            rx_state <= R_IDLE;
          end
        end
        R_DATA: if (bit_tick) begin
          bit_cnt <= FULL_BIT;
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_state <= R_STOP;
        end
        R_STOP: if (bit_tick) begin
          byte_valid <= rx_p1;
          frame_err  <= !rx_p1;
          rx_state   <= R_IDLE;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rx_state == R_DATA && bit_tick) rx_byte <= {rx_p1, rx_byte[7:1]};
  end

  assign ack_expire = (p_state == P_BUS) && !ack_i && (ack_cnt == ACK_LAST);
  assign overrun    = byte_valid && (p_state == P_BUS);

  // frame parser and bus master; error sources merge into one pulse
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      p_state    <= P_HDR;
      is_wr      <= 1'b0;
      ack_cnt    <= '0;
      stb_o      <= 1'b0;
      we_o       <= 1'b0;
      adr_o      <= '0;
      dat_o      <= '0;
      rd_dat_o   <= '0;
      rd_valid_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      rd_valid_o <= 1'b0;
      err_o      <= frame_err | ack_expire | overrun;
      case (p_state)
        P_HDR: if (byte_valid) begin
          if (rx_byte == 8'hA5) begin
            is_wr   <= 1'b1;
            p_state <= P_ADR;
          end else if (rx_byte == 8'h5A) begin
            is_wr   <= 1'b0;
            p_state <= P_ADR;
          end
        end
        P_ADR: if (byte_valid) begin
          adr_o <= rx_byte;
          if (is_wr) begin
            p_state <= P_DAT;
          end else begin
            stb_o   <= 1'b1;
            we_o    <= 1'b0;
            ack_cnt <= '0;
            p_state <= P_BUS;
          end
        end
        P_DAT: if (byte_valid) begin
          dat_o   <= rx_byte;
          stb_o   <= 1'b1;
          we_o    <= 1'b1;
          ack_cnt <= '0;
          p_state <= P_BUS;
        end
        P_BUS: begin
          // ack on the expiry edge takes priority over the timeout
          if (ack_i) begin
            stb_o   <= 1'b0;
            we_o    <= 1'b0;
            p_state <= P_HDR;
            if (!is_wr) begin
              rd_dat_o   <= dat_i;
              rd_valid_o <= 1'b1;
            end
          end else if (ack_expire) begin
            stb_o   <= 1'b0;
            we_o    <= 1'b0;
            p_state <= P_HDR;
          end else begin
            ack_cnt <= ack_cnt + 16'd1;
          end
        end
        default: p_state <= P_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus.sv
// Bench for uart_bus: byte-list frame model plus strobe-level slave/monitor, directed and random frames.
module tb_uart_bus;
  localparam int CPB    = 4;
  localparam int ACK_TO = 8;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       rx_i  = 1'b1;
  logic       ack_i = 1'b0;
  logic [7:0] dat_i = 8'h00;
  logic       stb_o, we_o, rd_valid_o, err_o;
  logic [7:0] adr_o, dat_o, rd_dat_o;

  uart_bus #(.CLKS_PER_BIT(CPB), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i), .ack_i(ack_i), .dat_i(dat_i),
    .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .rd_dat_o(rd_dat_o), .rd_valid_o(rd_valid_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit         we;
    logic [7:0] adr;
    logic [7:0] dat;
    int         delay;
    logic [7:0] rdata;
  } txn_t;

  txn_t       exp_q[$];
  logic [7:0] pend[$];
  int checks = 0, errors = 0;
  int err_exp = 0, err_obs = 0, rv_obs = 0, stb_cnt = 0;
  int force_delay = -1, force_rdata = -1;
  txn_t cur;
  bit   in_bus = 0, stb_prev = 0;
  int   k = 0, last_len = 0;
  logic [7:0] model_rd = 8'h00, last_adr = 8'h00, last_dat = 8'h00;
  bit   last_we = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic make_txn(input bit we, input logic [7:0] adr, input logic [7:0] dat);
    txn_t t;
    t.we    = we;
    t.adr   = adr;
    t.dat   = dat;
    t.delay = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 9));
    t.rdata = (force_rdata >= 0) ? 8'(force_rdata) : 8'($urandom_range(0, 255));
    if (t.delay + 1 > ACK_TO) err_exp++;
    exp_q.push_back(t);
  endtask

  // Frame rules on a list of received bytes: drop non-headers, emit when a frame is complete.
  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      err_exp++;
      return;
    end
    pend.push_back(b);
    while (pend.size() > 0 && pend[0] != 8'hA5 && pend[0] != 8'h5A) void'(pend.pop_front());
    if (pend.size() >= 2 && pend[0] == 8'h5A) begin
      make_txn(1'b0, pend[1], 8'h00);
      pend.delete();
    end else if (pend.size() >= 3 && pend[0] == 8'hA5) begin
      make_txn(1'b1, pend[1], pend[2]);
      pend.delete();
    end
  endtask

  task automatic send_raw(input logic [7:0] b, input bit stop_ok);
    rx_i = 1'b0;
    repeat (CPB) @(posedge clk_i);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(posedge clk_i);
      #1;
    end
    rx_i = stop_ok;
    repeat (CPB) @(posedge clk_i);
    #1;
    rx_i = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok, input int gap);
    send_raw(b, ok);
    model_byte(b, ok);
    repeat (gap + (ok ? 0 : 12)) @(posedge clk_i);
    #1;
  endtask

  task automatic drain(input string name);
    repeat (60) @(posedge clk_i);
    #1;
    chk({name, "_pending_strobes"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_err_count"}, 32'(err_obs), 32'(err_exp));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_stb"}, 32'(stb_o), 32'd0);
    chk({name, "_we"}, 32'(we_o), 32'd0);
    chk({name, "_adr"}, 32'(adr_o), 32'd0);
    chk({name, "_dat"}, 32'(dat_o), 32'd0);
    chk({name, "_rd_dat"}, 32'(rd_dat_o), 32'd0);
    chk({name, "_rd_valid"}, 32'(rd_valid_o), 32'd0);
    chk({name, "_err"}, 32'(err_o), 32'd0);
  endtask

  // Slave responder and per-cycle compare against the expected transaction list.
  always @(negedge clk_i) begin
    bit fall, acked;
    int exp_len;
    if (!rst_i) begin
      stb_prev = 0;
      in_bus   = 0;
      ack_i    = 1'b0;
      model_rd = 8'h00;
    end else begin
      fall  = 0;
      acked = 0;
      if (stb_o && !stb_prev) begin
        stb_cnt++;
        k = 0;
        if (exp_q.size() == 0) begin
          in_bus = 0;
          chk("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          cur      = exp_q.pop_front();
          in_bus   = 1;
          dat_i    = cur.rdata;
          last_adr = adr_o;
          last_dat = dat_o;
          last_we  = we_o;
        end
      end
      if (stb_o) begin
        k++;
        if (in_bus) begin
          chk("strobe_adr", 32'(adr_o), 32'(cur.adr));
          chk("strobe_we", 32'(we_o), 32'(cur.we));
          if (cur.we) chk("strobe_dat", 32'(dat_o), 32'(cur.dat));
        end
        ack_i = in_bus && (k == cur.delay + 1);
      end else if (stb_prev) begin
        fall  = 1;
        ack_i = 1'b0;
        if (in_bus) begin
          exp_len = (cur.delay + 1 < ACK_TO) ? cur.delay + 1 : ACK_TO;
          chk("strobe_len", 32'(k), 32'(exp_len));
          acked = (cur.delay + 1 <= ACK_TO);
          if (acked && !cur.we) model_rd = cur.rdata;
        end
        last_len = k;
      end
      chk("rd_valid", 32'(rd_valid_o), 32'(fall && in_bus && !cur.we && acked));
      chk("rd_dat", 32'(rd_dat_o), 32'(model_rd));
      if (!stb_o) chk("we_idle", 32'(we_o), 32'd0);
      if (err_o) err_obs++;
      if (rd_valid_o) rv_obs++;
      if (fall) in_bus = 0;
      stb_prev = stb_o;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    logic [7:0] a;
    logic [7:0] d;
    repeat (3) @(posedge clk_i);
    #1;
    chk_reset_outputs("reset");
    rst_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;

    // write frame, ack after 2 cycles
    force_delay = 2;
    send_byte(8'hA5, 1, 0); send_byte(8'h12, 1, 0); send_byte(8'h3C, 1, 0);
    drain("write");
    chk("write_len", 32'(last_len), 32'd3);
    chk("write_adr", 32'(last_adr), 32'h12);
    chk("write_dat", 32'(last_dat), 32'h3C);
    chk("write_we", 32'(last_we), 32'd1);
    chk("write_strobes", 32'(stb_cnt), 32'd1);
    chk("write_err", 32'(err_obs), 32'd0);

    // read frame returning 0x77
    force_delay = 1; force_rdata = 8'h77;
    send_byte(8'h5A, 1, 0); send_byte(8'h21, 1, 0);
    drain("read");
    chk("read_rd_dat", 32'(rd_dat_o), 32'h77);
    chk("read_we", 32'(last_we), 32'd0);
    chk("read_adr", 32'(last_adr), 32'h21);
    chk("read_rv_pulses", 32'(rv_obs), 32'd1);

    // resync over junk bytes
    force_delay = 0;
    send_byte(8'h00, 1, 3); send_byte(8'hFF, 1, 3);
    send_byte(8'hA5, 1, 0); send_byte(8'h40, 1, 0); send_byte(8'h01, 1, 0);
    drain("resync");
    chk("resync_strobes", 32'(stb_cnt), 32'd3);
    chk("resync_adr", 32'(last_adr), 32'h40);
    chk("resync_dat", 32'(last_dat), 32'h01);

    // framing error on the header byte
    force_rdata = 8'hC3;
    send_byte(8'hA5, 0, 0); send_byte(8'h5A, 1, 0); send_byte(8'h30, 1, 0);
    drain("framing");
    chk("framing_err", 32'(err_obs), 32'd1);
    chk("framing_strobes", 32'(stb_cnt), 32'd4);
    chk("framing_adr", 32'(last_adr), 32'h30);
    chk("framing_we", 32'(last_we), 32'd0);

    // no ack: timeout, then ack landing on the final allowed edge
    force_delay = 200;
    send_byte(8'hA5, 1, 0); send_byte(8'h33, 1, 0); send_byte(8'h44, 1, 0);
    drain("timeout");
    chk("timeout_len", 32'(last_len), 32'd8);
    chk("timeout_err", 32'(err_obs), 32'd2);
    force_delay = 7;
    send_byte(8'hA5, 1, 0); send_byte(8'h55, 1, 0); send_byte(8'h66, 1, 0);
    drain("ack_edge");
    chk("ack_edge_len", 32'(last_len), 32'd8);
    chk("ack_edge_err", 32'(err_obs), 32'd2);

    // reset during the data byte
    force_delay = 3;
    send_byte(8'hA5, 1, 0); send_byte(8'h12, 1, 0);
    fork
      send_raw(8'h3C, 1);
      begin
        repeat (15) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        chk_reset_outputs("rst_pdat");
      end
    join
    pend.delete();
    exp_q.delete();
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    send_byte(8'hA5, 1, 0); send_byte(8'h77, 1, 0); send_byte(8'h88, 1, 0);
    drain("after_rst1");
    chk("after_rst1_adr", 32'(last_adr), 32'h77);
    chk("after_rst1_dat", 32'(last_dat), 32'h88);

    // reset during an active strobe
    force_delay = 6;
    send_byte(8'hA5, 1, 0); send_byte(8'h99, 1, 0); send_byte(8'hAA, 1, 0);
    n = 0;
    while (!stb_o && n < 50) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk("rst_stb_seen", 32'(stb_o), 32'd1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk_reset_outputs("rst_strobe");
    pend.delete();
    exp_q.delete();
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    force_delay = 2; force_rdata = 8'h5E;
    send_byte(8'h5A, 1, 0); send_byte(8'h10, 1, 0);
    drain("after_rst2");
    chk("after_rst2_rd_dat", 32'(rd_dat_o), 32'h5E);

    // random frames, junk and framing errors
    force_delay = -1; force_rdata = -1;
    for (int it = 0; it < 60; it++) begin
      r = int'($urandom_range(0, 7));
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      if (r <= 2) begin
        send_byte(8'hA5, 1, int'($urandom_range(0, 6)));
        send_byte(a, 1, int'($urandom_range(0, 6)));
        send_byte(d, 1, int'($urandom_range(0, 6)));
      end else if (r <= 5) begin
        send_byte(8'h5A, 1, int'($urandom_range(0, 6)));
        send_byte(a, 1, int'($urandom_range(0, 6)));
      end else if (r == 6) begin
        send_byte(a, 1, int'($urandom_range(0, 6)));
      end else begin
        send_byte(a, 0, int'($urandom_range(0, 6)));
      end
    end
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
